// File: rtl/product_bcd_display.sv
// Sequential binary-to-BCD converter for the 16-bit product, with a
// multiplexed 7-segment scanner and optional leading-zero blanking.
module product_bcd_display #(
    parameter int unsigned SCAN_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic [6:0]  seg,
    output logic [4:0]  digit_en
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [15:0] shift_d;
    logic [19:0] scratch_q;
    logic [19:0] scratch_d;
    logic [19:0] adj;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [19:0] bcd_q;

    logic [SCAN_DIV-1:0] pre_q;
    logic [2:0]          idx_q;
    logic [2:0]          msd;
    logic [3:0]          cur;
    logic                blank;

    // Add-3 on every nibble >= 5 before the shift
    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < 5; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
        scratch_d = {adj[18:0], shift_q[15]};
        shift_d   = {shift_q[14:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q   <= value;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    shift_q   <= shift_d;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        bcd_q   <= scratch_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_q + SCAN_DIV'(1);
            if (&pre_q) begin
                idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
            end
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        msd = 3'd0;
        for (int k = 1; k < 5; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                msd = k[2:0];
            end
        end
    end

    always_comb begin
        unique case (idx_q)
            3'd1:    cur = bcd_q[7:4];
            3'd2:    cur = bcd_q[11:8];
            3'd3:    cur = bcd_q[15:12];
            3'd4:    cur = bcd_q[19:16];
            default: cur = bcd_q[3:0];
        endcase
    end

    assign blank    = blank_lz && (idx_q > msd);
    assign seg      = blank ? 7'h00 : seg_of(cur);
    assign digit_en = blank ? 5'b00000 : (5'b00001 << idx_q);
    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;

endmodule
